// File: rtl/up_counter.sv
// Cycle sequencer for the A5/1 datapath: counts through key load, frame load,
// mixing and keystream phases, then stops with a sticky DONE.
module up_counter #(
    parameter int WIDTH     = 9,
    parameter int KEY_LEN   = 64,
    parameter int FRAME_LEN = 22,
    parameter int MIX_LEN   = 100,
    parameter int OUT_LEN   = 228
) (
    input  logic             clk,
    input  logic             clr,
    output logic [WIDTH-1:0] Q,
    input  logic             ENABLE,
    output logic             STAGEONE,
    output logic             STAGETWO,
    output logic             STAGETHREE,
    output logic             OUTPUTSTAGE,
    output logic             DONE
);

    localparam int TOTAL = KEY_LEN + FRAME_LEN + MIX_LEN + OUT_LEN;

    // First count value of each later phase, and the final count.
    localparam logic [WIDTH-1:0] TWO_START   = WIDTH'(KEY_LEN);
    localparam logic [WIDTH-1:0] THREE_START = WIDTH'(KEY_LEN + FRAME_LEN);
    localparam logic [WIDTH-1:0] OUT_START   = WIDTH'(KEY_LEN + FRAME_LEN + MIX_LEN);
    localparam logic [WIDTH-1:0] LAST        = WIDTH'(TOTAL - 1);

    logic active;

    assign active = ENABLE && !DONE;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            Q    <= '0;
            DONE <= 1'b0;
        end else if (active) begin
            if (Q == LAST) begin
                DONE <= 1'b1;
            end else begin
                Q <= Q + 1'b1;
            end
        end
    end

    // Q never exceeds LAST, so the output phase needs no upper bound check.
    always_comb begin
        STAGEONE    = 1'b0;
        STAGETWO    = 1'b0;
        STAGETHREE  = 1'b0;
        OUTPUTSTAGE = 1'b0;
        if (active) begin
            if (Q < TWO_START) begin
                STAGEONE = 1'b1;
            end else if (Q < THREE_START) begin
                STAGETWO = 1'b1;
            end else if (Q < OUT_START) begin
                STAGETHREE = 1'b1;
            end else begin
                OUTPUTSTAGE = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_up_counter.sv
// Self-checking bench for up_counter: directed phases with randomized enable,
// compared each cycle against a phase-table reference model.
module tb_up_counter;

    localparam int TOTAL = 414;

    logic       clk;
    logic       clr;
    logic [8:0] Q;
    logic       ENABLE;
    logic       STAGEONE;
    logic       STAGETWO;
    logic       STAGETHREE;
    logic       OUTPUTSTAGE;
    logic       DONE;

    int checks = 0;
    int errors = 0;

    int m_q    = 0;
    bit m_done = 0;

    int  phase_len[4] = '{64, 22, 100, 228};
    int  tally_cnt[4] = '{0, 0, 0, 0};
    bit  tally = 0;

    up_counter dut (
        .clk        (clk),
        .clr        (clr),
        .Q          (Q),
        .ENABLE     (ENABLE),
        .STAGEONE   (STAGEONE),
        .STAGETWO   (STAGETWO),
        .STAGETHREE (STAGETHREE),
        .OUTPUTSTAGE(OUTPUTSTAGE),
        .DONE       (DONE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-hot expectation {OUTPUTSTAGE, STAGETHREE, STAGETWO, STAGEONE} from the phase table.
    function automatic logic [3:0] expStrobes();
        int start = 0;
        logic [3:0] r = 4'b0000;
        if (ENABLE === 1'b1 && !m_done && !clr) begin
            for (int k = 0; k < 4; k++) begin
                if (m_q >= start && m_q < start + phase_len[k]) r[k] = 1'b1;
                start += phase_len[k];
            end
        end else if (ENABLE === 1'b1 && clr) begin
            r = 4'b0001;
        end
        return r;
    endfunction

    task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h (model q=%0d)", tag, obs, exp, m_q);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, ".Q"}, {7'd0, Q}, 16'(m_q));
        checkVal({tag, ".DONE"}, {15'd0, DONE}, {15'd0, m_done});
        checkVal({tag, ".strobes"}, {12'd0, OUTPUTSTAGE, STAGETHREE, STAGETWO, STAGEONE},
                 {12'd0, expStrobes()});
    endtask

    // Drive ENABLE for one cycle, advance the model on the edge, check 1ns later.
    task automatic applyStimulus(input logic en, input string tag);
        ENABLE = en;
        #1;
        if (tally) begin
            if (STAGEONE)    tally_cnt[0]++;
            if (STAGETWO)    tally_cnt[1]++;
            if (STAGETHREE)  tally_cnt[2]++;
            if (OUTPUTSTAGE) tally_cnt[3]++;
        end
        @(posedge clk);
        if (clr) begin
            m_q    = 0;
            m_done = 0;
        end else if (en && !m_done) begin
            if (m_q == TOTAL - 1) m_done = 1;
            else m_q++;
        end
        #1;
        checkOutput(tag);
    endtask

    task automatic asyncClear(input string tag);
        #2;
        clr = 1'b1;
        #1;
        m_q    = 0;
        m_done = 0;
        checkOutput(tag);
        clr = 1'b0;
    endtask

    initial begin
        int guard;
        clr    = 1'b1;
        ENABLE = 1'b0;

        // Reset hold with enable low, then enable raised while still in reset.
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, "reset_hold");
        ENABLE = 1'b1;
        #1;
        checkOutput("reset_enable");
        applyStimulus(1'b1, "reset_enable_clk");

        // Clean enabled run from 0 to completion, tallying strobe cycles.
        clr   = 1'b0;
        tally = 1'b1;
        guard = 0;
        while (!m_done && guard < 1000) begin
            applyStimulus(1'b1, "full_run");
            guard++;
        end
        tally = 1'b0;
        checkVal("full_run_bound", {15'd0, m_done}, 16'd1);
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, "done_hold");
        for (int k = 0; k < 4; k++)
            checkVal($sformatf("stage%0d_cycles", k), 16'(tally_cnt[k]), 16'(phase_len[k]));

        // Asynchronous clear after DONE.
        asyncClear("clr_after_done");

        // Random enable up to Q=100, then a 10-cycle pause and resume.
        guard = 0;
        while (m_q < 100 && guard < 2000) begin
            applyStimulus(($urandom % 4) != 0, "rand_to_100");
            guard++;
        end
        checkVal("reach_100", 16'(m_q), 16'd100);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, "pause");
        applyStimulus(1'b1, "resume");

        // Random enable up to Q=250, then clear between edges.
        guard = 0;
        while (m_q < 250 && guard < 2000) begin
            applyStimulus(($urandom % 4) != 0, "rand_to_250");
            guard++;
        end
        checkVal("reach_250", 16'(m_q), 16'd250);
        ENABLE = 1'b1;
        asyncClear("clr_mid_output");

        // Random enable run to completion, then hold.
        guard = 0;
        while (!m_done && guard < 3000) begin
            applyStimulus(($urandom % 4) != 0, "rand_to_done");
            guard++;
        end
        checkVal("rand_done_bound", {15'd0, m_done}, 16'd1);
        for (int i = 0; i < 20; i++) applyStimulus($urandom % 2 == 1, "rand_done_hold");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
